// File: rtl/key_note_encoder.sv
// key_note_encoder: synchronises and debounces eight piano keys, priority-encodes
// the clean key vector into a 4-bit note code and pulses note_strobe on every
// change of that code.
module key_note_encoder #(
  parameter int unsigned DEBOUNCE   = 32'd1000000,
  parameter int unsigned CNT_W      = 32'd20,
  parameter bit          KEY_ACT_HI = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] KEY,
  output logic [3:0] note,
  output logic       note_strobe,
  output logic [7:0] stable_keys
);

  // Synchroniser idle level: whatever reads as "not pressed" after polarity
  localparam logic [7:0]       SYNC_IDLE = KEY_ACT_HI ? 8'h00 : 8'hFF;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  logic [7:0]       sync1_r;
  logic [7:0]       sync2_r;
  logic [7:0]       pressed_s;
  logic [CNT_W-1:0] cnt_r [8];
  logic [3:0]       enc_s;

  // Two-flop synchroniser for every raw key line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_r <= SYNC_IDLE;
      sync2_r <= SYNC_IDLE;
    end else begin
      sync1_r <= KEY;
      sync2_r <= sync1_r;
    end
  end

  // Apply key polarity after synchronisation so that 1 always means pressed
  always_comb begin
    if (KEY_ACT_HI) begin
      pressed_s = sync2_r;
    end else begin
      pressed_s = ~sync2_r;
    end
  end

  // Per-key debounce: accept a new level only after DEBOUNCE consecutive differing samples
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stable_keys <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pressed_s[i] == stable_keys[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          stable_keys[i] <= pressed_s[i];
          cnt_r[i]       <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Priority encoder: lowest pressed key index wins, code is index+1, 0 when idle
  always_comb begin
    enc_s = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      enc_s = stable_keys[i] ? 4'(i + 1) : enc_s;
    end
  end

  // Registered note code plus a one-cycle strobe whenever the code changes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      note        <= 4'd0;
      note_strobe <= 1'b0;
    end else begin
      note        <= enc_s;
      note_strobe <= (enc_s != note);
    end
  end

endmodule
